imm_gen_pipe: RTL and testbench

Buffered, parametrised immediate generator for the RV decode stage. It accepts one 32-bit instruction per cycle over a valid/ready handshake and decodes the immediate for every base format (I, S, B, U, J). It sign-extends the immediate to XLEN and queues the result, with format code, illegal flag and a pass-through tag, in a DEPTH-entry FIFO for the execute stage. It also keeps a saturating count of illegal opcodes seen.

---
 rtl/imm_gen_pipe.sv | 142 ++++++++++++++
 tb/tb_imm_gen_pipe.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// Immediate generator for RV decode: decodes I/S/B/U/J immediates and queues them in a DEPTH-entry FIFO.
// Build option IMMGEN_UPPER_EN enables U/J decode; without it those opcodes are reported illegal.
module imm_gen_pipe #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2,
  parameter int TAG_W = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_inst,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_imm,
  output logic [2:0]                 out_fmt,
  output logic                       out_illegal,
  output logic [TAG_W-1:0]           out_tag,
  output logic [$clog2(DEPTH):0]     level,
  output logic [15:0]                illegal_count
);
  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // ready never depends combinationally on the opposite side's valid or ready.
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [6:0]  op;
  logic [63:0] imm64;
  logic [2:0]  dec_fmt;
  logic        dec_illegal;
  logic [XLEN-1:0] dec_imm;

  assign op = in_inst[6:0];

  always_comb begin
    dec_fmt = 3'd7;
    imm64   = '0;
    case (op)
      7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111: begin
        dec_fmt = 3'd1;
        imm64   = {{52{in_inst[31]}}, in_inst[31:20]};
      end
      7'b0100011: begin
        dec_fmt = 3'd2;
        imm64   = {{52{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      end
      7'b1100011: begin
        dec_fmt = 3'd3;
        imm64   = {{51{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
      end
`ifdef IMMGEN_UPPER_EN
      7'b0110111, 7'b0010111: begin
        dec_fmt = 3'd4;
        imm64   = {{32{in_inst[31]}}, in_inst[31:12], 12'b0};
      end
      7'b1101111: begin
        dec_fmt = 3'd5;
        imm64   = {{43{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
      end
`endif
      7'b0110011, 7'b0111011: begin
        dec_fmt = 3'd0;
      end
      default: begin
        dec_fmt = 3'd7;
      end
    endcase
  end

`ifdef IMMGEN_UPPER_EN
`else
  // Bits 19:12 only feed the U/J extractors, which are absent in this build.
  logic unused_upper;
  assign unused_upper = ^in_inst[19:12];
`endif

  // Truncation keeps XLEN=32 U immediates unextended.
  assign dec_imm     = imm64[XLEN-1:0];
  assign dec_illegal = (dec_fmt == 3'd7);

  logic [XLEN-1:0]  mem_imm [DEPTH];
  logic [2:0]       mem_fmt [DEPTH];
  logic [TAG_W-1:0] mem_tag [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;

  assign in_ready  = (level < LVL_W'(DEPTH));
  assign out_valid = (level != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_imm[i] <= '0;
        mem_fmt[i] <= '0;
        mem_tag[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        mem_imm[wr_ptr] <= dec_imm;
        mem_fmt[wr_ptr] <= dec_fmt;
        mem_tag[wr_ptr] <= in_tag;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        level <= level + LVL_W'(1);
      end else if (pop && !push) begin
        level <= level - LVL_W'(1);
      end
    end
  end

  // Dropped (flushed) instructions are not counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_count <= '0;
    end else if (!flush && push && dec_illegal && (illegal_count != 16'hFFFF)) begin
      illegal_count <= illegal_count + 16'd1;
    end
  end

  assign out_imm     = mem_imm[rd_ptr];
  assign out_fmt     = mem_fmt[rd_ptr];
  assign out_tag     = mem_tag[rd_ptr];
  assign out_illegal = (out_fmt == 3'd7);

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe (XLEN=64, DEPTH=2); U/J expectations follow IMMGEN_UPPER_EN.
module tb_imm_gen_pipe;
  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [63:0] in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_imm;
  logic [2:0]  out_fmt;
  logic        out_illegal;
  logic [63:0] out_tag;
  logic [1:0]  level;
  logic [15:0] illegal_count;

  int checks;
  int failures;
  logic [15:0] exp_ill;

  logic [31:0] v_inst [10];
  logic [63:0] v_imm  [10];
  logic [2:0]  v_fmt  [10];

  imm_gen_pipe #(.XLEN(64), .DEPTH(2), .TAG_W(64)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_fmt(out_fmt),
    .out_illegal(out_illegal), .out_tag(out_tag), .level(level), .illegal_count(illegal_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_tag = '0; out_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    exp_ill = 16'd0;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_imm !== 64'd0) begin failures++; $display("FAIL reset_out_imm got=%h exp=0", out_imm); end
    checks++; if (out_fmt !== 3'd0) begin failures++; $display("FAIL reset_out_fmt got=%0d exp=0", out_fmt); end
    checks++; if (out_illegal !== 1'b0) begin failures++; $display("FAIL reset_out_illegal got=%b exp=0", out_illegal); end
    checks++; if (out_tag !== 64'd0) begin failures++; $display("FAIL reset_out_tag got=%h exp=0", out_tag); end
    checks++; if (level !== 2'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
    checks++; if (illegal_count !== 16'd0) begin failures++; $display("FAIL reset_illegal_count got=%h exp=0", illegal_count); end
  endtask

  task automatic test_load();
    out_ready = 1'b1;
    in_valid = 1'b1; in_inst = 32'hFF813083; in_tag = 64'h0000_0000_0000_1000;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL ld_valid got=%b exp=1", out_valid); end
    checks++; if (out_imm !== 64'hFFFFFFFFFFFFFFF8) begin failures++; $display("FAIL ld_imm got=%h exp=fffffffffffffff8", out_imm); end
    checks++; if (out_fmt !== 3'd1) begin failures++; $display("FAIL ld_fmt got=%0d exp=1", out_fmt); end
    checks++; if (out_illegal !== 1'b0) begin failures++; $display("FAIL ld_illegal got=%b exp=0", out_illegal); end
    checks++; if (out_tag !== 64'h1000) begin failures++; $display("FAIL ld_tag got=%h exp=1000", out_tag); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ld_drained got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    in_valid = 1'b1; in_inst = 32'hFE113C23; in_tag = 64'h2000;
    step();
    in_inst = 32'hFE000EE3; in_tag = 64'h2004;
    checks++; if (out_imm !== 64'hFFFFFFFFFFFFFFF8) begin failures++; $display("FAIL b2b_sd_imm got=%h exp=fffffffffffffff8", out_imm); end
    checks++; if (out_fmt !== 3'd2) begin failures++; $display("FAIL b2b_sd_fmt got=%0d exp=2", out_fmt); end
    step();
    in_valid = 1'b0;
    checks++; if (out_imm !== 64'hFFFFFFFFFFFFFFFC) begin failures++; $display("FAIL b2b_beq_imm got=%h exp=fffffffffffffffc", out_imm); end
    checks++; if (out_fmt !== 3'd3) begin failures++; $display("FAIL b2b_beq_fmt got=%0d exp=3", out_fmt); end
    checks++; if (out_tag !== 64'h2004) begin failures++; $display("FAIL b2b_beq_tag got=%h exp=2004", out_tag); end
    checks++; if (level !== 2'd1) begin failures++; $display("FAIL b2b_level got=%0d exp=1", level); end
    step();
  endtask

  task automatic test_formats();
    v_inst[0] = 32'hFF813083; v_imm[0] = 64'hFFFFFFFFFFFFFFF8; v_fmt[0] = 3'd1;
    v_inst[1] = 32'h7FF00093; v_imm[1] = 64'h00000000000007FF; v_fmt[1] = 3'd1;
    v_inst[2] = 32'h00412083; v_imm[2] = 64'h0000000000000004; v_fmt[2] = 3'd1;
    v_inst[3] = 32'hFE113C23; v_imm[3] = 64'hFFFFFFFFFFFFFFF8; v_fmt[3] = 3'd2;
    v_inst[4] = 32'hFE000EE3; v_imm[4] = 64'hFFFFFFFFFFFFFFFC; v_fmt[4] = 3'd3;
`ifdef IMMGEN_UPPER_EN
    v_inst[5] = 32'h800000B7; v_imm[5] = 64'hFFFFFFFF80000000; v_fmt[5] = 3'd4;
    v_inst[6] = 32'h12345117; v_imm[6] = 64'h0000000012345000; v_fmt[6] = 3'd4;
    v_inst[7] = 32'hFFDFF06F; v_imm[7] = 64'hFFFFFFFFFFFFFFFC; v_fmt[7] = 3'd5;
`else
    v_inst[5] = 32'h800000B7; v_imm[5] = 64'd0; v_fmt[5] = 3'd7;
    v_inst[6] = 32'h12345117; v_imm[6] = 64'd0; v_fmt[6] = 3'd7;
    v_inst[7] = 32'hFFDFF06F; v_imm[7] = 64'd0; v_fmt[7] = 3'd7;
`endif
    v_inst[8] = 32'h003100B3; v_imm[8] = 64'd0; v_fmt[8] = 3'd0;
    v_inst[9] = 32'h0000007F; v_imm[9] = 64'd0; v_fmt[9] = 3'd7;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_inst = v_inst[i]; in_tag = 64'(i) + 64'hA0;
      if (v_fmt[i] == 3'd7) exp_ill = exp_ill + 16'd1;
      step();
      checks++; if (out_imm !== v_imm[i]) begin failures++; $display("FAIL fmt_imm[%0d] got=%h exp=%h", i, out_imm, v_imm[i]); end
      checks++; if (out_fmt !== v_fmt[i]) begin failures++; $display("FAIL fmt_fmt[%0d] got=%0d exp=%0d", i, out_fmt, v_fmt[i]); end
      checks++; if (out_illegal !== (v_fmt[i] == 3'd7)) begin failures++; $display("FAIL fmt_illegal[%0d] got=%b exp=%b", i, out_illegal, (v_fmt[i] == 3'd7)); end
      checks++; if (out_tag !== 64'(i) + 64'hA0) begin failures++; $display("FAIL fmt_tag[%0d] got=%h exp=%h", i, out_tag, 64'(i) + 64'hA0); end
    end
    in_valid = 1'b0;
    step();
    checks++; if (illegal_count !== exp_ill) begin failures++; $display("FAIL fmt_illegal_count got=%h exp=%h", illegal_count, exp_ill); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h00100093; in_tag = 64'd1;
    step();
    in_inst = 32'h00200093; in_tag = 64'd2;
    step();
    in_inst = 32'h00300093; in_tag = 64'd3;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full_ready got=%b exp=0", in_ready); end
    checks++; if (level !== 2'd2) begin failures++; $display("FAIL bp_full_level got=%0d exp=2", level); end
    step();
    checks++; if (out_tag !== 64'd1) begin failures++; $display("FAIL bp_hold_tag got=%h exp=1", out_tag); end
    checks++; if (out_imm !== 64'd1) begin failures++; $display("FAIL bp_hold_imm got=%h exp=1", out_imm); end
    checks++; if (level !== 2'd2) begin failures++; $display("FAIL bp_hold_level got=%0d exp=2", level); end
    out_ready = 1'b1;
    step();
    checks++; if (out_tag !== 64'd2) begin failures++; $display("FAIL bp_drain1_tag got=%h exp=2", out_tag); end
    checks++; if (level !== 2'd1) begin failures++; $display("FAIL bp_drain1_level got=%0d exp=1", level); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_reraise_ready got=%b exp=1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (out_tag !== 64'd3) begin failures++; $display("FAIL bp_third_tag got=%h exp=3", out_tag); end
    checks++; if (out_imm !== 64'd3) begin failures++; $display("FAIL bp_third_imm got=%h exp=3", out_imm); end
    checks++; if (level !== 2'd1) begin failures++; $display("FAIL bp_third_level got=%0d exp=1", level); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h00500093; in_tag = 64'h10;
    step();
    checks++; if (level !== 2'd1) begin failures++; $display("FAIL flush_pre_level got=%0d exp=1", level); end
    in_inst = 32'h0000007F; in_tag = 64'h11; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (level !== 2'd0) begin failures++; $display("FAIL flush_level got=%0d exp=0", level); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
    checks++; if (illegal_count !== exp_ill) begin failures++; $display("FAIL flush_illegal_count got=%h exp=%h", illegal_count, exp_ill); end
    out_ready = 1'b1;
    in_valid = 1'b1; in_inst = 32'h00600093; in_tag = 64'h12;
    step();
    in_valid = 1'b0;
    checks++; if (out_tag !== 64'h12) begin failures++; $display("FAIL flush_next_tag got=%h exp=12", out_tag); end
    checks++; if (out_imm !== 64'd6) begin failures++; $display("FAIL flush_next_imm got=%h exp=6", out_imm); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_next_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_saturation();
    reset = 1'b1; step(); reset = 1'b0;
    exp_ill = 16'd0;
    out_ready = 1'b1;
    in_valid = 1'b1; in_inst = 32'h0000007F; in_tag = 64'h77;
    for (int i = 0; i < 65534; i++) step();
    checks++; if (illegal_count !== 16'hFFFE) begin failures++; $display("FAIL sat_near got=%h exp=fffe", illegal_count); end
    for (int i = 0; i < 6; i++) step();
    checks++; if (illegal_count !== 16'hFFFF) begin failures++; $display("FAIL sat_hold got=%h exp=ffff", illegal_count); end
    checks++; if (out_fmt !== 3'd7) begin failures++; $display("FAIL sat_fmt got=%0d exp=7", out_fmt); end
    out_ready = 1'b0; flush = 1'b1; reset = 1'b1;
    step();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    checks++; if (illegal_count !== 16'd0) begin failures++; $display("FAIL sat_reset_count got=%h exp=0", illegal_count); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL sat_reset_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL sat_reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_tag !== 64'd0) begin failures++; $display("FAIL sat_reset_tag got=%h exp=0", out_tag); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_load();
    test_back_to_back();
    test_formats();
    test_backpressure();
    test_flush();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
